// File: rtl/inst_axi_fetch.sv
// inst_axi_fetch: turns one fetch request into a single AXI INCR read burst and presents an aligned instruction pair.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned PC skips AXI and returns an error pair for the front end to trap on.
module inst_axi_fetch #(
  parameter int         BURST_LEN = 2,
  parameter logic [3:0] ARID      = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [3:0]  rid,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  output logic        rready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_1,
  output logic [31:0] inst_2,
  output logic        inst_2_valid,
  output logic [31:0] inst_pc,
  output logic        inst_err
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, DRAIN} state_t;
  state_t     state, state_n;
  logic [1:0] cnt;
  logic       flushed, beat, req, bad_pc;
  assign arid    = ARID;
  assign arlen   = 4'(BURST_LEN - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign fetch_ready = state == IDLE;
  assign arvalid     = state == ADDR;
  assign rready      = (state == DATA) | (state == DRAIN);
  assign inst_valid  = state == HOLD;
  assign beat = rvalid & rready & (rid == ARID);
  assign req  = fetch_ready & fetch_req & ~flush;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bad_pc = fetch_pc[1:0] != 2'd0;
`else
  assign bad_pc = 1'b0;
`endif
  // A flush coinciding with the final beat has nothing left to drain, so it returns straight to IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req ? (bad_pc ? HOLD : ADDR) : IDLE;
      ADDR:    state_n = arready ? ((flushed | flush) ? DRAIN : DATA) : ADDR;
      DATA:    state_n = (beat & rlast) ? (flush ? IDLE : HOLD) : (flush ? DRAIN : DATA);
      HOLD:    state_n = (flush | inst_ready) ? IDLE : HOLD;
      DRAIN:   state_n = (beat & rlast) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      araddr       <= 32'd0;
      inst_1       <= 32'd0;
      inst_2       <= 32'd0;
      inst_2_valid <= 1'b0;
      inst_pc      <= 32'd0;
      inst_err     <= 1'b0;
      cnt          <= 2'd0;
      flushed      <= 1'b0;
    end else begin
      state <= state_n;
      if (req) begin
        araddr       <= fetch_pc;
        inst_pc      <= fetch_pc;
        inst_1       <= 32'd0;
        inst_2       <= 32'd0;
        inst_2_valid <= 1'b0;
        inst_err     <= bad_pc;
        cnt          <= 2'd0;
        flushed      <= 1'b0;
      end
      if (state == ADDR && flush) flushed <= 1'b1;
      // Beats past BURST_LEN still count but never overwrite a slot.
      if (state == DATA && beat && !flush) begin
        if (cnt == 2'd0) inst_1 <= rdata;
        if (cnt == 2'd1 && BURST_LEN == 2) inst_2 <= rdata;
        inst_err <= inst_err | (rresp != 2'b00);
        cnt      <= cnt + {1'b0, cnt != 2'd3};
        if (rlast) inst_2_valid <= (BURST_LEN == 2) && (cnt != 2'd0);
      end
    end
  end
endmodule

// File: doc/inst_axi_fetch.md
Name: inst_axi_fetch

Overview:
- Instruction-fetch bridge between the IF_1/IF_2 PC generators and the AXI read channel. It replaces the ad-hoc arvalid/rvalid logic in the core top.
- Accepts one fetch request per PC and issues a single AXI INCR read burst.
- Collects the returned beats into a 2-slot pair buffer and presents an aligned instruction pair to the dual-issue front end with a valid/ready handshake.
- Supports a branch/exception flush that discards in-flight data without violating AXI rules.

Parameters:
- BURST_LEN, 2, beats per fetch; legal values 1 or 2; drives arlen = BURST_LEN-1.
- ARID, 0, 4-bit AXI ID driven on arid and matched against rid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_req  in  1  request to fetch at fetch_pc
- fetch_pc  in  32  PC of the first instruction
- fetch_ready  out  1  block can accept a request
- flush  in  1  discard the current fetch (branch/exception redirect)
- arvalid  out  1  AXI read address valid
- araddr  out  32  AXI read address
- arid  out  4  = ARID
- arlen  out  4  = BURST_LEN-1
- arsize  out  3  = 3'b010
- arburst  out  2  = 2'b01 (INCR)
- arlock  out  2  = 0
- arcache  out  4  = 0
- arprot  out  3  = 0
- arready  in  1  AXI address accepted
- rvalid  in  1  AXI read data valid
- rdata  in  32  AXI read data
- rid  in  4  AXI read ID
- rresp  in  2  AXI read response
- rlast  in  1  last beat of the burst
- rready  out  1  AXI read data ready
- inst_valid  out  1  instruction pair available
- inst_ready  in  1  front end consumes the pair
- inst_1  out  32  instruction at inst_pc
- inst_2  out  32  instruction at inst_pc+4
- inst_2_valid  out  1  inst_2 holds real data
- inst_pc  out  32  PC of inst_1
- inst_err  out  1  rresp was non-OKAY on any beat (or misaligned PC, see optional feature)

Behaviour:
- Clock and reset: clk is the only clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - arvalid = 0, araddr = 0, rready = 0
  - inst_valid = 0, inst_1 = 0, inst_2 = 0, inst_2_valid = 0, inst_pc = 0, inst_err = 0
  - fetch_ready = 1, beat counter = 0
  - Reset mid-burst: the block returns to IDLE and never waits for the outstanding beats.
- Constant AXI fields (arid, arlen, arsize, arburst, arlock, arcache, arprot) are driven combinationally from the parameters.
- IDLE:
  - fetch_ready = 1.
  - On fetch_req & !flush: latch fetch_pc into araddr and inst_pc, clear the slots, inst_err and the beat counter, set arvalid = 1, go to ADDR.
  - arvalid rises the cycle after acceptance.
- ADDR:
  - arvalid and araddr are held stable until arready (AXI rule). fetch_ready = 0.
  - On arvalid & arready: arvalid = 0, rready = 1, go to DATA. If flush has been seen, go to DRAIN instead.
  - A flush in ADDR is remembered in a sticky flag; arvalid is never dropped early.
- DATA:
  - On rvalid & rready & (rid == ARID): store rdata into slot[cnt], OR (rresp != 0) into inst_err, increment cnt.
  - Beats with a mismatching rid are accepted and ignored.
  - On a matching rlast beat: rready = 0, go to HOLD, inst_2_valid = (cnt reached 2).
  - A beat whose cnt would exceed BURST_LEN-1 is discarded (slot write suppressed).
  - flush in DATA: go to DRAIN; beats already in the slots are discarded.
- HOLD:
  - inst_valid = 1; inst_1, inst_2, inst_pc, inst_err and inst_2_valid are stable until inst_valid & inst_ready.
  - On handshake: inst_valid = 0, go to IDLE. fetch_ready returns the next cycle, so the minimum request-to-request period is 4 cycles plus AXI latency.
  - flush in HOLD: inst_valid = 0, go to IDLE. If inst_ready and flush arrive together, flush wins; the pair counts as not consumed.
- DRAIN:
  - rready = 1; matching beats are discarded.
  - Matching rlast moves the block to IDLE with rready = 0.
  - flush in DRAIN has no further effect.
- Simultaneous fetch_req & flush in IDLE: the request is ignored.
- fetch_req outside IDLE is ignored; the front end must hold the request until fetch_ready.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined: a request with fetch_pc[1:0] != 0 issues no AXI transaction. The block goes directly to HOLD on the next cycle with inst_1 = inst_2 = 32'h0 (NOP), inst_2_valid = 0, inst_err = 1 and inst_pc = fetch_pc, so the front end raises an address-error exception.
- When undefined: no alignment check; araddr = fetch_pc unchanged.

Test Plan:
- Basic pair: fetch_pc = 0xBFC00000, arready same cycle, beats 0x24080001 then 0x24090002 with rlast on the second -> araddr = 0xBFC00000, arlen = 1; HOLD with inst_1 = 0x24080001, inst_2 = 0x24090002, inst_2_valid = 1, inst_pc = 0xBFC00000, inst_err = 0.
- Back-pressure: arready delayed 3 cycles and inst_ready low 5 cycles -> arvalid and araddr stable throughout ADDR; outputs stable throughout HOLD; fetch_ready returns one cycle after the handshake.
- Flush in ADDR: flush pulse while arready = 0, then arready and beats arrive -> arvalid stays high until arready; both beats consumed in DRAIN; inst_valid never rises; fetch_ready = 1 after rlast.
- Flush in DATA: flush after the first beat -> second beat drained; a new request to 0xBFC00100 then completes normally with the new data only.
- Error response: second beat rresp = 2'b10 -> inst_err = 1 with both instructions delivered. Separately, rid = 4'h3 beat interleaved -> ignored; pair assembled correctly.
- FETCH_ALIGN_CHECK_EN build: fetch_pc = 0xBFC00002 -> no arvalid; next cycle inst_valid = 1, inst_err = 1, inst_1 = 0; without the macro araddr = 0xBFC00002.
